mod_sub_pipe: RTL and testbench

Streaming modular subtractor, the counterpart to the combinational modular adder. It computes out = (x - y) mod q for the difference leg of the Gentleman-Sande/INTT butterfly. Two-stage pipeline with valid/ready handshakes on input and output, full throughput, and backpressure stall. The modulus is loaded through a config handshake and held in a register, so the datapath has no per-sample q input.

---
 rtl/mod_sub_pipe_pkg.sv | 7 +
 rtl/mod_sub_core.sv | 23 ++
 rtl/mod_sub_pipe.sv | 91 +++++++++
 tb/tb_mod_sub_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_sub_pipe_pkg.sv
// Shared NTT constants: datapath width and the default prime modulus (2^28 - 2^16 + 1).
package mod_sub_pipe_pkg;

    localparam int unsigned NTT_W = 28;
    localparam logic [NTT_W-1:0] NTT_Q = 28'd268369921;

endpackage

// File: rtl/mod_sub_core.sv
// Combinational front half of (x - y) mod q: raw W-bit difference, borrow and operand range flag.
module mod_sub_core
    import mod_sub_pipe_pkg::*;
#(
    parameter int unsigned W = NTT_W
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] q,
    output logic [W-1:0] diff_c,
    output logic         borrow_c,
    output logic         range_err_c
);

    logic [W:0] wide;

    // One extra bit so the sign of x - y comes out as the borrow.
    assign wide        = {1'b0, x} - {1'b0, y};
    assign diff_c      = wide[W-1:0];
    assign borrow_c    = wide[W];
    assign range_err_c = (x >= q) || (y >= q);

endmodule

// File: rtl/mod_sub_pipe.sv
// Two-stage streaming modular subtractor with valid/ready handshakes and a config-loaded modulus.
module mod_sub_pipe
    import mod_sub_pipe_pkg::*;
#(
    parameter int unsigned     W       = NTT_W,
    parameter logic [W-1:0]    Q_RESET = W'(NTT_Q)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_q,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_range_err
);

    logic [W-1:0] q_reg;
    logic [W-1:0] core_diff;
    logic         core_borrow;
    logic         core_err;

    logic         s1_valid;
    logic [W-1:0] s1_diff;
    logic         s1_borrow;
    logic         s1_err;

    logic         s2_valid;
    logic         s2_adv;
    logic         s1_en;

    mod_sub_core #(
        .W (W)
    ) u_core (
        .x           (in_x),
        .y           (in_y),
        .q           (q_reg),
        .diff_c      (core_diff),
        .borrow_c    (core_borrow),
        .range_err_c (core_err)
    );

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_en     = !s1_valid || s2_adv;
    assign in_ready  = s1_en;
    assign out_valid = s2_valid;
    // Modulus only changes with the pipe empty, so every sample sees a single q end to end.
    assign cfg_ready = !s1_valid && !s2_valid && !in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= Q_RESET;
        end else if (cfg_valid && cfg_ready) begin
            q_reg <= cfg_q;
        end
    end

    // Stage 1: raw difference, borrow and range flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_borrow <= 1'b0;
            s1_err    <= 1'b0;
        end else if (s1_en) begin
            s1_valid  <= in_valid;
            s1_diff   <= core_diff;
            s1_borrow <= core_borrow;
            s1_err    <= core_err;
        end
    end

    // Stage 2: add q back on borrow; carry out of the W-bit add is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            out_data      <= '0;
            out_range_err <= 1'b0;
        end else if (s2_adv) begin
            s2_valid      <= s1_valid;
            out_data      <= s1_borrow ? W'(s1_diff + q_reg) : s1_diff;
            out_range_err <= s1_err;
        end
    end

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed self-checking bench for mod_sub_pipe.
module tb_mod_sub_pipe;

    localparam int unsigned W  = 28;
    localparam logic [W-1:0] QD = 28'd268369921;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_q;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_range_err;

    int n_cmp = 0;
    int n_err = 0;

    logic         irdy, crdy, ovld, oerr;
    logic [W-1:0] od;

    mod_sub_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_q         (cfg_q),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_range_err (out_range_err)
    );

    always #5 clk = ~clk;

    // Reference: signed integer difference, wrapped back into [0, q) when negative.
    function automatic logic [W-1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] q);
        longint d;
        d = longint'(x) - longint'(y);
        if (d < 0) d = d + longint'(q);
        return W'(d);
    endfunction

    // Drive one cycle (called 1 ns after a rising edge), sample pre-edge outputs, step past the edge.
    task automatic cycle(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ordy, input logic cv, input logic [W-1:0] cq);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        out_ready = ordy;
        cfg_valid = cv;
        cfg_q     = cq;
        #1;
        irdy = in_ready;
        crdy = cfg_ready;
        ovld = out_valid;
        od   = out_data;
        oerr = out_range_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b0;
        cfg_valid = 1'b0;
        cfg_q     = '0;
        #3;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_cmp++; if (out_range_err !== 1'b0) begin n_err++; $display("FAIL reset_range_err: got %b want 0", out_range_err); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single samples under the reset modulus, checking the two-edge latency each time.
    task automatic test_basic();
        logic [W-1:0] vx[5];
        logic [W-1:0] vy[5];
        logic [W-1:0] ve[5];
        vx = '{28'd5, 28'd3, 28'd0,         28'd7, 28'd268369920};
        vy = '{28'd3, 28'd5, 28'd268369920, 28'd7, 28'd0};
        ve = '{28'd2, 28'd268369919, 28'd1, 28'd0, 28'd268369920};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, vx[i], vy[i], 1'b1, 1'b0, '0);
            n_cmp++; if (irdy !== 1'b1) begin n_err++; $display("FAIL basic_in_ready[%0d]: got %b want 1", i, irdy); end
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
            n_cmp++; if (ovld !== 1'b0) begin n_err++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, ovld); end
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
            n_cmp++; if (ovld !== 1'b1) begin n_err++; $display("FAIL basic_valid[%0d]: got %b want 1", i, ovld); end
            n_cmp++; if (od !== ve[i]) begin n_err++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, od, ve[i]); end
            n_cmp++; if (oerr !== 1'b0) begin n_err++; $display("FAIL basic_err[%0d]: got %b want 0", i, oerr); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        logic [W-1:0] xs, ys;
        logic         v;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 300) begin
            v  = (sent < 100);
            xs = W'($urandom_range(32'(QD) - 1));
            ys = W'($urandom_range(32'(QD) - 1));
            cycle(v, xs, ys, 1'b1, 1'b0, '0);
            if (ovld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL b2b_extra: got result %0d want none", od);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if ({oerr, od} !== e) begin n_err++; $display("FAIL b2b_data[%0d]: got %0d/%b want %0d/%b", got, od, oerr, e[W-1:0], e[W]); end
                    got++;
                end
            end
            if (v) begin
                n_cmp++; if (irdy !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", sent, irdy); end
                if (irdy) begin
                    exp_q.push_back({1'b0, ref_sub(xs, ys, QD)});
                    sent++;
                end
            end
            cyc++;
        end
        n_cmp++; if (got !== 100) begin n_err++; $display("FAIL b2b_count: got %0d want 100", got); end
        n_cmp++; if (cyc !== 102) begin n_err++; $display("FAIL b2b_cycles: got %0d want 102", cyc); end
    endtask

    task automatic test_stall();
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        logic [W-1:0] sx[8];
        logic [W-1:0] sy[8];
        logic [W-1:0] held;
        logic         v, ordy;
        int idx, got, cyc;
        sx = '{28'd100, 28'd0, 28'd5000, 28'd268369920, 28'd1, 28'd77, 28'd123456, 28'd9};
        sy = '{28'd40,  28'd1, 28'd6000, 28'd268369919, 28'd1, 28'd78, 28'd654321, 28'd268369920};
        idx = 0; got = 0; cyc = 0; held = '0;
        while (got < 8 && cyc < 60) begin
            ordy = (cyc >= 5);
            v    = (idx < 8);
            cycle(v, sx[idx % 8], sy[idx % 8], ordy, 1'b0, '0);
            if (cyc < 2 || cyc == 5) begin
                n_cmp++; if (irdy !== 1'b1) begin n_err++; $display("FAIL stall_in_ready_hi[c%0d]: got %b want 1", cyc, irdy); end
            end
            if (cyc == 2) held = od;
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++; if (irdy !== 1'b0) begin n_err++; $display("FAIL stall_in_ready_lo[c%0d]: got %b want 0", cyc, irdy); end
                n_cmp++; if (ovld !== 1'b1) begin n_err++; $display("FAIL stall_valid[c%0d]: got %b want 1", cyc, ovld); end
                n_cmp++; if (od !== held) begin n_err++; $display("FAIL stall_hold[c%0d]: got %0d want %0d", cyc, od, held); end
            end
            if (ovld && ordy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++; $display("FAIL stall_dup: got result %0d want none", od);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++; if ({oerr, od} !== e) begin n_err++; $display("FAIL stall_data[%0d]: got %0d want %0d", got, od, e[W-1:0]); end
                    got++;
                end
            end
            if (v && irdy) begin
                exp_q.push_back({1'b0, ref_sub(sx[idx], sy[idx], QD)});
                idx++;
            end
            cyc++;
        end
        n_cmp++; if (got !== 8) begin n_err++; $display("FAIL stall_count: got %0d want 8", got); end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (ovld !== 1'b0) begin n_err++; $display("FAIL stall_trailing: got %b want 0", ovld); end
    endtask

    task automatic test_config();
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 28'd7681);
        n_cmp++; if (crdy !== 1'b1) begin n_err++; $display("FAIL cfg_idle_ready: got %b want 1", crdy); end
        cycle(1'b1, 28'd1, 28'd2, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (ovld !== 1'b1 || od !== 28'd7680) begin n_err++; $display("FAIL cfg_q7681: got %b/%0d want 1/7680", ovld, od); end
        // Offer a new modulus while a sample is in flight; it must wait for the drain.
        cycle(1'b1, 28'd1, 28'd2, 1'b1, 1'b1, 28'd12289);
        n_cmp++; if (crdy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_in: got %b want 0", crdy); end
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 28'd12289);
        n_cmp++; if (crdy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_s1: got %b want 0", crdy); end
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 28'd12289);
        n_cmp++; if (crdy !== 1'b0) begin n_err++; $display("FAIL cfg_busy_s2: got %b want 0", crdy); end
        n_cmp++; if (ovld !== 1'b1 || od !== 28'd7680) begin n_err++; $display("FAIL cfg_old_q: got %b/%0d want 1/7680", ovld, od); end
        cycle(1'b0, '0, '0, 1'b1, 1'b1, 28'd12289);
        n_cmp++; if (crdy !== 1'b1) begin n_err++; $display("FAIL cfg_drained: got %b want 1", crdy); end
        cycle(1'b1, 28'd1, 28'd2, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (ovld !== 1'b1 || od !== 28'd12288) begin n_err++; $display("FAIL cfg_new_q: got %b/%0d want 1/12288", ovld, od); end
    endtask

    // Reset with a full pipe, then confirm the modulus is back to the default and range flagging.
    task automatic test_reset_mid();
        logic [W-1:0] vx[3];
        logic [W-1:0] vy[3];
        logic [W-1:0] ve[3];
        logic         vr[3];
        cycle(1'b1, 28'd10, 28'd4, 1'b1, 1'b0, '0);
        cycle(1'b1, 28'd11, 28'd4, 1'b1, 1'b0, '0);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_valid: got %b want 1", out_valid); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_mid_data: got %0d want 0", out_data); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_cfg_ready: got %b want 1", cfg_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (ovld !== 1'b0) begin n_err++; $display("FAIL rst_mid_flush0: got %b want 0", ovld); end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (ovld !== 1'b0) begin n_err++; $display("FAIL rst_mid_flush1: got %b want 0", ovld); end
        vx = '{28'd0,         28'd268369921, 28'd3};
        vy = '{28'd268369920, 28'd0,         28'd268369925};
        ve = '{28'd1,         28'd268369921, 28'd268435455};
        vr = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, vx[i], vy[i], 1'b1, 1'b0, '0);
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
            cycle(1'b0, '0, '0, 1'b1, 1'b0, '0);
            n_cmp++; if (ovld !== 1'b1) begin n_err++; $display("FAIL range_valid[%0d]: got %b want 1", i, ovld); end
            n_cmp++; if (od !== ve[i]) begin n_err++; $display("FAIL range_data[%0d]: got %0d want %0d", i, od, ve[i]); end
            n_cmp++; if (oerr !== vr[i]) begin n_err++; $display("FAIL range_err[%0d]: got %b want %b", i, oerr, vr[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_config();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
